bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have parameter WIDTH, default 16: result width in bits; minimum 16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  conversion request; sampled only in IDLE.
REQ-005 SHALL have port neg  input  1  sign of the entered number; 1 means negative.
REQ-006 SHALL have ports D3, D2, D1, D0  input  4 each  BCD digits: thousands, hundreds, tens, ones.
REQ-007 SHALL have port data  output  WIDTH  two's-complement binary result.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  invalid-digit flag; valid only in the done cycle.

Function
REQ-011 SHALL implement the FSM states IDLE, ACCUM and FIN.
REQ-012 SHALL, when start=1 in IDLE at edge N, capture D3..D0 and neg, clear the accumulator and the digit index, and enter ACCUM.
REQ-013 SHALL, in ACCUM at edges N+1..N+4, set acc <= acc*10 + digit, taking the digits in the order D3, D2, D1, D0.
REQ-014 SHALL form acc*10 as (acc<<3)+(acc<<1) with no multiplier, WIDTH bits wide.
REQ-015 SHALL, at edge N+5 (FIN), load data with -acc if the captured neg is 1, else acc; then return to IDLE.
REQ-016 SHALL assert done for exactly the one cycle following edge N+5; latency from start to done is 5 cycles.
REQ-017 SHALL hold busy high from edge N through edge N+5 and low in the done cycle.
REQ-018 SHALL ignore start while busy; the captured digits and neg stay fixed throughout the conversion.
REQ-019 SHALL accept a start asserted in the done cycle, giving back-to-back conversions every 6 cycles.
REQ-020 SHALL produce data=0 for a negative zero (neg=1, all digits 0).
REQ-021 SHALL hold data stable between completions.

Reset
REQ-022 SHALL, on rst=1 at any edge including mid-conversion, force state IDLE, data=0, busy=0, done=0, err=0, and clear the accumulator and digit index.
REQ-023 SHALL give rst priority over start at the same edge.

Configuration
REQ-024 SHALL, with BCD_CHECK_EN defined, flag any captured digit above 9: at FIN, err=1, done=1 and data unchanged.
REQ-025 SHALL, without BCD_CHECK_EN defined, tie err to 0 and feed digits above 9 arithmetically as-is.

Structure
REQ-026 SHALL take the state encoding, N_DIGITS=4 and DIGIT_MAX=9 from the shared package calc_pkg.
REQ-027 SHALL instantiate one sub-module, bcd_mac10, which computes acc*10+digit combinationally, WIDTH wide.

Verification
REQ-028 SHALL cover: D=1,2,3,4, neg=0, start pulse -> busy for 5 cycles, then done=1 with data=0x04D2 and err=0.
REQ-029 SHALL cover: D=9,9,9,9, neg=1 -> data=0xD8F1 (-9999); with D=0,0,0,0, neg=1 -> data=0x0000.
REQ-030 SHALL cover: start while busy with D changed to 5,5,5,5 -> ignored; result is 0x04D2 from the first capture.
REQ-031 SHALL cover: rst at cycle 3 of a conversion -> next cycle data=0, busy=0, and no done pulse.
REQ-032 SHALL cover: D=A,0,0,0 -> with BCD_CHECK_EN, err=1 and data unchanged; without it, data=0x2710 and err=0.
REQ-033 SHALL cover: start asserted in the done cycle -> second done exactly 6 cycles after the first.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the BCD-to-binary conversion block.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int unsigned N_DIGITS  = 4;
  localparam int unsigned DIGIT_MAX = 9;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit using shifts only, WIDTH bits wide.
module bcd_mac10 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] result
);

  assign result = (acc << 3) + (acc << 1) + WIDTH'(digit);

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 4-digit signed BCD to two's-complement converter.
// Optional invalid-digit detection is enabled by defining BCD_CHECK_EN.
module bcd_to_binary
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             neg,
  input  logic [3:0]       D3,
  input  logic [3:0]       D2,
  input  logic [3:0]       D1,
  input  logic [3:0]       D0,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] acc_q, acc_n, mac_out;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             neg_q;
  logic [3:0]       dig_q [N_DIGITS];
  logic             cap;

  // dig_q[0] holds the most significant digit so the index walks D3..D0
  bcd_mac10 #(.WIDTH(WIDTH)) u_mac (
    .acc    (acc_q),
    .digit  (dig_q[idx_q]),
    .result (mac_out)
  );

`ifdef BCD_CHECK_EN
  logic err_q, err_n;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!digit_ok(dig_q[i])) bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    idx_n   = idx_q;
    data_n  = data_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    cap     = 1'b0;
`ifdef BCD_CHECK_EN
    err_n   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          cap     = 1'b1;
          acc_n   = '0;
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        acc_n = mac_out;
        idx_n = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_n = FIN;
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
`ifdef BCD_CHECK_EN
        if (bad_digit) err_n = 1'b1;
        else           data_n = neg_q ? -acc_q : acc_q;
`else
        data_n = neg_q ? -acc_q : acc_q;
`endif
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef BCD_CHECK_EN
      err_q   <= err_n;
`endif
    end
  end

  // Captured operands only change on an accepted start, so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      dig_q[0] <= D3;
      dig_q[1] <= D2;
      dig_q[2] <= D1;
      dig_q[3] <= D0;
      neg_q    <= neg;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef BCD_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary (default WIDTH=16).
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst, start, neg;
  logic [3:0]  D3, D2, D1, D0;
  logic [15:0] data;
  logic        busy, done, err;

  int checks   = 0;
  int failures = 0;

  bcd_to_binary #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .neg   (neg),
    .D3    (D3),
    .D2    (D2),
    .D1    (D1),
    .D0    (D0),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic n);
    D3 = a; D2 = b; D1 = c; D0 = d; neg = n;
  endtask

  // Leaves the bench in the done cycle.
  task automatic run_conv(input string tag, input logic [15:0] exp_data, input logic exp_err);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nodone"}, done, 0);
    end
    step();
    check({tag, "_done"}, done, 1);
    check({tag, "_busylow"}, busy, 0);
    check({tag, "_data"}, data, exp_data);
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    set_d(0, 0, 0, 0, 0);
    step();
    start = 1'b1;
    step();
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("rst_prio_busy", busy, 0);

    set_d(1, 2, 3, 4, 0);
    run_conv("c1234", 16'h04D2, 0);
    step();
    check("c1234_pulse", done, 0);
    check("c1234_hold", data, 16'h04D2);
    step();
    check("c1234_hold2", data, 16'h04D2);

    set_d(9, 9, 9, 9, 1);
    run_conv("n9999", 16'hD8F1, 0);
    step();

    set_d(0, 0, 0, 0, 1);
    run_conv("negzero", 16'h0000, 0);
    step();

    // start while busy with different operands must be ignored
    set_d(1, 2, 3, 4, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_d(5, 5, 5, 5, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("ign_nodone", done, 0);
    step();
    check("ign_done", done, 1);
    check("ign_data", data, 16'h04D2);
    step();
    check("ign_nodup", done, 0);
    check("ign_busy", busy, 0);

    // reset asserted at the third edge of a conversion
    set_d(9, 9, 9, 9, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_nodone", done, 0);
      check("midrst_idle", busy, 0);
    end

    // back-to-back: start accepted in the done cycle
    set_d(1, 2, 3, 4, 0);
    run_conv("b2b_a", 16'h04D2, 0);
    set_d(0, 0, 4, 2, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 12) begin
      step();
      n++;
    end
    check("b2b_gap", n, 6);
    check("b2b_data", data, 16'h002A);
    check("b2b_busy", busy, 0);
    step();

    set_d(4'hA, 0, 0, 0, 0);
`ifdef BCD_CHECK_EN
    run_conv("digA", 16'h002A, 1);
`else
    run_conv("digA", 16'h2710, 0);
`endif
    step();
    check("digA_errclr", err, 0);
    check("digA_pulse", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
